// File: rtl/lock_scheduler_if.sv
// Command/ACK stream bundle between accelerators and the lock scheduler.
// Signal names match the original flat port list so callers map one-to-one.
interface lock_scheduler_if #(
  parameter int ACC_BITS = 4
);
  logic [63:0]         inStream_TDATA;
  logic                inStream_TVALID;
  logic [ACC_BITS-1:0] inStream_TID;
  logic                inStream_TREADY;
  logic [7:0]          outStream_TDATA;
  logic                outStream_TVALID;
  logic                outStream_TREADY;
  logic [ACC_BITS-1:0] outStream_TDEST;

  modport master (
    output inStream_TDATA, inStream_TVALID, inStream_TID, outStream_TREADY,
    input  inStream_TREADY, outStream_TDATA, outStream_TVALID, outStream_TDEST
  );

  modport slave (
    input  inStream_TDATA, inStream_TVALID, inStream_TID, outStream_TREADY,
    output inStream_TREADY, outStream_TDATA, outStream_TVALID, outStream_TDEST
  );
endinterface

// File: rtl/lock_scheduler.sv
// Per-lock ownership with deferred grants: waiters are queued in a bitmap and
// the next owner is picked round-robin after the releasing owner.
module lock_scheduler #(
  parameter int MAX_ACCS  = 16,
  parameter int NUM_LOCKS = 4
) (
  input logic             clk,
  input logic             rst,
  lock_scheduler_if.slave bus
);
  localparam int ACC_BITS     = $clog2(MAX_ACCS);
  localparam int CMD_TYPE_L   = 0;
  localparam int CMD_TYPE_H   = 7;
  localparam int LOCK_ID_L    = 32;
  localparam int LOCK_ID_H    = 39;
  localparam int LOCK_ID_BITS = LOCK_ID_H - LOCK_ID_L + 1;
  localparam int LIDX_W       = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;

  localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK_CODE = 8'h05;
  localparam logic [7:0] ACK_REJECT_CODE = 8'h00;
  localparam logic [7:0] ACK_OK_CODE     = 8'h01;

  typedef enum logic [1:0] {
    READ_HEADER,
    DECODE,
    SCAN,
    SEND_ACK
  } state_t;

  state_t                    state;
  logic [ACC_BITS-1:0]       req_tid;
  logic [7:0]                req_cmd;
  logic [LOCK_ID_BITS-1:0]   req_lid;
  logic                      busy    [NUM_LOCKS];
  logic [ACC_BITS-1:0]       owner   [NUM_LOCKS];
  logic [MAX_ACCS-1:0]       waiters [NUM_LOCKS];
  logic [7:0]                out_data;
  logic [ACC_BITS-1:0]       out_dest;
  logic                      out_valid;

  logic [LIDX_W-1:0]         lidx;
  logic                      lid_ok;
  logic                      cur_busy;
  logic [ACC_BITS-1:0]       cur_owner;
  logic [MAX_ACCS-1:0]       cur_waiters;
  logic [ACC_BITS-1:0]       rr_sel;
  logic [ACC_BITS-1:0]       cand;
  logic                      rr_found;

  assign lidx        = req_lid[LIDX_W-1:0];
  assign lid_ok      = {1'b0, req_lid} < (LOCK_ID_BITS + 1)'(NUM_LOCKS);
  assign cur_busy    = busy[lidx];
  assign cur_owner   = owner[lidx];
  assign cur_waiters = waiters[lidx];

  // Search starts one past the current owner so the releasing owner's
  // neighbours are served first; the owner itself is never a waiter.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= MAX_ACCS; i++) begin
      cand = ACC_BITS'((32'(cur_owner) + i) % MAX_ACCS);
      if (!rr_found && cur_waiters[cand]) begin
        rr_found = 1'b1;
        rr_sel   = cand;
      end
    end
  end

  // Ready is decoded from state and masked by rst so it reads 0 during reset
  // and 1 in the very first cycle after release.
  assign bus.inStream_TREADY  = (state == READ_HEADER) && !rst;
  assign bus.outStream_TDATA  = out_data;
  assign bus.outStream_TDEST  = out_dest;
  assign bus.outStream_TVALID = out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= READ_HEADER;
      req_tid   <= '0;
      req_cmd   <= '0;
      req_lid   <= '0;
      out_data  <= '0;
      out_dest  <= '0;
      out_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_LOCKS; i++) begin
        busy[i]    <= 1'b0;
        owner[i]   <= '0;
        waiters[i] <= '0;
      end
    end else begin
      case (state)
        READ_HEADER: begin
          if (bus.inStream_TVALID) begin
            req_tid <= bus.inStream_TID;
            req_cmd <= bus.inStream_TDATA[CMD_TYPE_H:CMD_TYPE_L];
            req_lid <= bus.inStream_TDATA[LOCK_ID_H:LOCK_ID_L];
            state   <= DECODE;
          end
        end

        DECODE: begin
          state <= READ_HEADER;
          if (!lid_ok) begin
            if (req_cmd == CMD_LOCK_CODE) begin
              out_data  <= ACK_REJECT_CODE;
              out_dest  <= req_tid;
              out_valid <= 1'b1;
              state     <= SEND_ACK;
            end
          end else if (req_cmd == CMD_LOCK_CODE) begin
            if (!cur_busy) begin
              busy[lidx]  <= 1'b1;
              owner[lidx] <= req_tid;
              out_data    <= ACK_OK_CODE;
              out_dest    <= req_tid;
              out_valid   <= 1'b1;
              state       <= SEND_ACK;
            end else if (cur_owner == req_tid) begin
              out_data  <= ACK_REJECT_CODE;
              out_dest  <= req_tid;
              out_valid <= 1'b1;
              state     <= SEND_ACK;
            end else begin
              waiters[lidx][req_tid] <= 1'b1;
            end
          end else if (req_cmd == CMD_UNLOCK_CODE && cur_busy && cur_owner == req_tid) begin
            if (cur_waiters == '0) begin
              busy[lidx] <= 1'b0;
            end else begin
              state <= SCAN;
            end
          end
        end

        SCAN: begin
          waiters[lidx][rr_sel] <= 1'b0;
          owner[lidx]           <= rr_sel;
          out_data              <= ACK_OK_CODE;
          out_dest              <= rr_sel;
          out_valid             <= 1'b1;
          state                 <= SEND_ACK;
        end

        SEND_ACK: begin
          if (bus.outStream_TREADY) begin
            out_valid <= 1'b0;
            state     <= READ_HEADER;
          end
        end

        default: state <= READ_HEADER;
      endcase
    end
  end
endmodule

// File: tb/tb_lock_scheduler.sv
// Directed bench for lock_scheduler: grant, deferred round-robin grant, reject,
// out-of-range IDs, ACK back-pressure and reset during a pending ACK.
module tb_lock_scheduler;
  localparam logic [7:0] LOCK   = 8'h04;
  localparam logic [7:0] UNLOCK = 8'h05;
  localparam logic [7:0] OK     = 8'h01;
  localparam logic [7:0] REJ    = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lock_scheduler_if #(.ACC_BITS(4)) bus ();

  lock_scheduler #(.MAX_ACCS(16), .NUM_LOCKS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] tid, input logic [7:0] cmd, input logic [7:0] id);
    logic [63:0] d;
    int n;
    d = '0;
    d[7:0]   = cmd;
    d[39:32] = id;
    @(negedge clk);
    bus.inStream_TID    = tid;
    bus.inStream_TDATA  = d;
    bus.inStream_TVALID = 1'b1;
    n = 0;
    while (!bus.inStream_TREADY && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hs_ready", {63'd0, bus.inStream_TREADY}, 64'd1);
    @(posedge clk);
    #1;
    bus.inStream_TVALID = 1'b0;
  endtask

  // Called #1 after the handshake edge; lat counts cycles from handshake to TVALID.
  task automatic check_ack(input logic [7:0] code, input logic [3:0] dest,
                           input int lat, input int hold, input string tag);
    check({tag, "_early"}, {63'd0, bus.outStream_TVALID}, 64'd0);
    for (int k = 0; k < lat - 2; k++) begin
      @(posedge clk); #1;
      check({tag, "_early"}, {63'd0, bus.outStream_TVALID}, 64'd0);
    end
    @(posedge clk); #1;
    check({tag, "_valid"}, {63'd0, bus.outStream_TVALID}, 64'd1);
    check({tag, "_data"},  {56'd0, bus.outStream_TDATA}, {56'd0, code});
    check({tag, "_dest"},  {60'd0, bus.outStream_TDEST}, {60'd0, dest});
    check({tag, "_inrdy"}, {63'd0, bus.inStream_TREADY}, 64'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_hvalid"}, {63'd0, bus.outStream_TVALID}, 64'd1);
      check({tag, "_hdata"},  {56'd0, bus.outStream_TDATA}, {56'd0, code});
      check({tag, "_hdest"},  {60'd0, bus.outStream_TDEST}, {60'd0, dest});
      check({tag, "_hinrdy"}, {63'd0, bus.inStream_TREADY}, 64'd0);
    end
    @(negedge clk);
    bus.outStream_TREADY = 1'b1;
    @(posedge clk); #1;
    bus.outStream_TREADY = 1'b0;
    check({tag, "_done"},  {63'd0, bus.outStream_TVALID}, 64'd0);
    check({tag, "_back"},  {63'd0, bus.inStream_TREADY}, 64'd1);
  endtask

  task automatic no_ack(input string tag);
    check({tag, "_dec"}, {63'd0, bus.outStream_TVALID}, 64'd0);
    @(posedge clk); #1;
    check({tag, "_noack"}, {63'd0, bus.outStream_TVALID}, 64'd0);
    check({tag, "_back"},  {63'd0, bus.inStream_TREADY}, 64'd1);
  endtask

  initial begin
    bus.inStream_TDATA   = '0;
    bus.inStream_TVALID  = 1'b0;
    bus.inStream_TID     = '0;
    bus.outStream_TREADY = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_inrdy", {63'd0, bus.inStream_TREADY}, 64'd0);
    check("rst_valid", {63'd0, bus.outStream_TVALID}, 64'd0);
    check("rst_data",  {56'd0, bus.outStream_TDATA}, 64'd0);
    check("rst_dest",  {60'd0, bus.outStream_TDEST}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_inrdy", {63'd0, bus.inStream_TREADY}, 64'd1);

    // Simple grant
    send(4'd3, LOCK, 8'd0);    check_ack(OK, 4'd3, 2, 0, "l0_a3");

    // Deferred grants, round-robin after owner 3: 5 before 1
    send(4'd5, LOCK, 8'd0);    no_ack("l0_w5");
    send(4'd1, LOCK, 8'd0);    no_ack("l0_w1");
    send(4'd5, LOCK, 8'd0);    no_ack("l0_w5_again");
    send(4'd3, UNLOCK, 8'd0);  check_ack(OK, 4'd5, 3, 0, "l0_g5");
    send(4'd5, UNLOCK, 8'd0);  check_ack(OK, 4'd1, 3, 0, "l0_g1");
    send(4'd1, UNLOCK, 8'd0);  no_ack("l0_free");
    send(4'd9, LOCK, 8'd0);    check_ack(OK, 4'd9, 2, 0, "l0_a9");

    // Round-robin from owner 9: 12 first, then wrap to 2
    send(4'd2, LOCK, 8'd0);    no_ack("l0_w2");
    send(4'd12, LOCK, 8'd0);   no_ack("l0_w12");
    send(4'd9, UNLOCK, 8'd0);  check_ack(OK, 4'd12, 3, 0, "l0_g12");
    send(4'd12, UNLOCK, 8'd0); check_ack(OK, 4'd2, 3, 0, "l0_g2wrap");
    send(4'd2, UNLOCK, 8'd0);  no_ack("l0_free2");

    // Re-lock by owner rejected; foreign unlock ignored
    send(4'd2, LOCK, 8'd1);    check_ack(OK, 4'd2, 2, 0, "l1_a2");
    send(4'd2, LOCK, 8'd1);    check_ack(REJ, 4'd2, 2, 0, "l1_rej");
    send(4'd7, UNLOCK, 8'd1);  no_ack("l1_foreign_unlock");
    send(4'd7, LOCK, 8'd1);    no_ack("l1_w7");
    send(4'd4, LOCK, 8'd0);    check_ack(OK, 4'd4, 2, 0, "l0_indep");
    send(4'd2, UNLOCK, 8'd1);  check_ack(OK, 4'd7, 3, 0, "l1_g7");
    send(4'd7, UNLOCK, 8'd1);  no_ack("l1_free");
    send(4'd4, UNLOCK, 8'd0);  no_ack("l0_free3");

    // Out-of-range lock ID and unknown command
    send(4'd6, LOCK, 8'd4);    check_ack(REJ, 4'd6, 2, 0, "oor_lock");
    send(4'd6, UNLOCK, 8'd4);  no_ack("oor_unlock");
    send(4'd6, 8'h07, 8'd0);   no_ack("other_cmd");
    send(4'd6, LOCK, 8'd0);    check_ack(OK, 4'd6, 2, 0, "l0_after_oor");
    send(4'd6, UNLOCK, 8'd0);  no_ack("l0_free4");

    // Back-pressure on the ACK for 10 cycles
    send(4'd8, LOCK, 8'd3);    check_ack(OK, 4'd8, 2, 10, "bp");

    // Reset while an ACK is pending
    send(4'd10, LOCK, 8'd2);   check_ack(OK, 4'd10, 2, 0, "l2_a10");
    send(4'd4, LOCK, 8'd2);    no_ack("l2_w4");
    send(4'd10, LOCK, 8'd2);
    @(posedge clk); #1;
    check("mid_valid", {63'd0, bus.outStream_TVALID}, 64'd1);
    check("mid_data",  {56'd0, bus.outStream_TDATA}, {56'd0, REJ});
    check("mid_dest",  {60'd0, bus.outStream_TDEST}, 64'd10);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, bus.outStream_TVALID}, 64'd0);
    check("arst_inrdy", {63'd0, bus.inStream_TREADY}, 64'd0);
    check("arst_dest",  {60'd0, bus.outStream_TDEST}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arel_inrdy", {63'd0, bus.inStream_TREADY}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("arel_noack", {63'd0, bus.outStream_TVALID}, 64'd0);
    send(4'd4, LOCK, 8'd2);    check_ack(OK, 4'd4, 2, 0, "l2_a4");
    send(4'd4, UNLOCK, 8'd2);  no_ack("l2_nowaiters");
    send(4'd11, LOCK, 8'd3);   check_ack(OK, 4'd11, 2, 0, "l3_free");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
